// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one async-FIFO write port among N_REQ requesters.
// Define FIFO_ARB_STATS_EN to build the per-requester beat counters on stat_beats.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 32,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 16
) (
    input  logic                       wr_clk,
    input  logic                       rst_n_wr,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       wr_en,
    output logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_full,
    output logic                       grant_valid,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    input  logic                       stat_clr,
    output logic [N_REQ*CNT_W-1:0]     stat_beats
);

    localparam int IDW = $clog2(N_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    logic           state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [BCW-1:0] burstCnt_q, burstCnt_d;

    logic           beat;
    logic           burstEnd;
    logic           pickFound;
    logic [IDW-1:0] pickId;
    logic [IDW-1:0] candId;
    int             candIdx;

    // Search starts just after the last granted requester so nobody can be starved.
    always_comb begin
        pickFound = 1'b0;
        pickId    = '0;
        candIdx   = 0;
        candId    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            candIdx = (int'(ptr_q) + i) % N_REQ;
            candId  = candIdx[IDW-1:0];
            if (!pickFound && req_valid[candId]) begin
                pickFound = 1'b1;
                pickId    = candId;
            end
        end
    end

    assign grant_valid = (state_q == ST_BURST);
    assign grant_id    = grant_q;
    assign beat        = grant_valid & req_valid[grant_q] & ~wr_full;
    assign burstEnd    = grant_valid &
                         (~req_valid[grant_q] |
                          (beat & (req_last[grant_q] | (burstCnt_q == BCW'(MAX_BURST - 1)))));
    assign wr_en       = beat;
    assign wr_data     = beat ? req_data[int'(grant_q) * DATA_W +: DATA_W] : '0;

    always_comb begin
        req_ready = '0;
        if (beat) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        burstCnt_d = burstCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pickFound) begin
                    grant_d    = pickId;
                    ptr_d      = pickId;
                    burstCnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            default: begin
                if (beat) begin
                    burstCnt_d = burstCnt_q + BCW'(1);
                end
                if (burstEnd) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n_wr) begin
        if (!rst_n_wr) begin
            state_q    <= ST_IDLE;
            ptr_q      <= IDW'(N_REQ - 1);
            grant_q    <= '0;
            burstCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            burstCnt_q <= burstCnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // A clear wins over a simultaneous beat; counters stick at all-ones.
    for (genvar g = 0; g < N_REQ; g++) begin : gStat
        logic [CNT_W-1:0] statCnt_q;

        always_ff @(posedge wr_clk or negedge rst_n_wr) begin
            if (!rst_n_wr) begin
                statCnt_q <= '0;
            end else if (stat_clr) begin
                statCnt_q <= '0;
            end else if (beat && (grant_q == IDW'(g)) && (statCnt_q != '1)) begin
                statCnt_q <= statCnt_q + CNT_W'(1);
            end
        end

        assign stat_beats[g*CNT_W +: CNT_W] = statCnt_q;
    end
`else
    logic unusedStatClr;
    assign unusedStatClr = stat_clr;
    assign stat_beats    = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: cycle table for arbitration/backpressure,
// then scoreboard-driven sequences (bursts, round-robin, reset, stats when FIFO_ARB_STATS_EN).
module tb_fifo_wr_arbiter;

    localparam int DATA_W    = 32;
    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 8;
    localparam int CNT_W     = 4;

    logic                    wr_clk = 1'b0;
    logic                    rst_n_wr;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    wr_en;
    logic [DATA_W-1:0]       wr_data;
    logic                    wr_full;
    logic                    grant_valid;
    logic [1:0]              grant_id;
    logic                    stat_clr;
    logic [N_REQ*CNT_W-1:0]  stat_beats;

    fifo_wr_arbiter #(
        .DATA_W   (DATA_W),
        .N_REQ    (N_REQ),
        .MAX_BURST(MAX_BURST),
        .CNT_W    (CNT_W)
    ) dut (
        .wr_clk     (wr_clk),
        .rst_n_wr   (rst_n_wr),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .stat_clr   (stat_clr),
        .stat_beats (stat_beats)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic       expWrEn;
        logic [3:0] expReady;
        logic       expGv;
        logic [1:0] expGid;
    } vec_t;

    typedef struct packed {
        int          id;
        logic [31:0] data;
        logic        last;
    } beat_t;

    vec_t  vecs [17];
    beat_t srcQ [$];
    beat_t sbQ  [$];
    int    wrCycles [$];
    int    expCyc [$];
    int    cyc;
    int    compared   = 0;
    int    mismatched = 0;

    function automatic logic [31:0] mkData(int id, int k);
        return 32'hA000_0000 | (32'(id) << 16) | 32'(k);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int r);
        req_valid = v.valid;
        req_last  = v.last;
        wr_full   = v.full;
        for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = mkData(i, 100 + r);
    endtask

    task automatic driveSources();
        req_valid = '0;
        req_last  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bit found = 1'b0;
            for (int j = 0; j < srcQ.size(); j++) begin
                if (!found && srcQ[j].id == i) begin
                    found                        = 1'b1;
                    req_valid[i]                 = 1'b1;
                    req_last[i]                  = srcQ[j].last;
                    req_data[i*DATA_W +: DATA_W] = srcQ[j].data;
                end
            end
        end
    endtask

    task automatic popSource(input int id);
        for (int j = 0; j < srcQ.size(); j++) begin
            if (srcQ[j].id == id) begin
                srcQ.delete(j);
                return;
            end
        end
    endtask

    task automatic loadBeats(input int id, input int n, input bit lastEach, input bit lastFinal,
                             input bit toSb);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.id   = id;
            b.data = mkData(id, k);
            b.last = lastEach || (lastFinal && k == n - 1);
            srcQ.push_back(b);
            if (toSb) sbQ.push_back(b);
        end
    endtask

    // Monitor at the falling edge, then advance the requesters after the rising edge.
    task automatic stepCycle();
        logic [3:0] acc;
        beat_t      e;
        @(negedge wr_clk);
        if (wr_en) begin
            wrCycles.push_back(cyc);
            if (sbQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL sb_extra_beat: got wr_data %0h at cycle %0d, expected no write",
                         wr_data, cyc);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sb_wr_data", 64'(wr_data), 64'(e.data));
                checkOutput("sb_grant_id", 64'(grant_id), 64'(e.id));
                checkOutput("sb_req_ready", 64'(req_ready), 64'(1) << e.id);
            end
        end
        acc = req_ready;
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < N_REQ; i++) if (acc[i]) popSource(i);
        driveSources();
        cyc++;
    endtask

    task automatic doReset();
        @(posedge wr_clk);
        #1;
        rst_n_wr = 1'b0;
        srcQ.delete();
        sbQ.delete();
        wrCycles.delete();
        expCyc.delete();
        wr_full  = 1'b0;
        stat_clr = 1'b0;
        driveSources();
        @(posedge wr_clk);
        @(posedge wr_clk);
        #1;
        rst_n_wr = 1'b1;
        cyc      = 0;
    endtask

    task automatic checkCycles(input string name);
        checkOutput({name, "_sb_left"}, 64'(sbQ.size()), 64'd0);
        checkOutput({name, "_beat_count"}, 64'(wrCycles.size()), 64'(expCyc.size()));
        for (int i = 0; i < expCyc.size() && i < wrCycles.size(); i++)
            checkOutput({name, "_beat_cycle"}, 64'(wrCycles[i]), 64'(expCyc[i]));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // valid last full | wrEn ready gv gid
        vecs[0]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[2]  = '{4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[3]  = '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[5]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[6]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[7]  = '{4'b1101, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};
        vecs[8]  = '{4'b1101, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[9]  = '{4'b1101, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[10] = '{4'b1101, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[11] = '{4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[12] = '{4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};
        vecs[13] = '{4'b1001, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[14] = '{4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3};
        vecs[15] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[16] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};

        rst_n_wr  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        wr_full   = 1'b0;
        stat_clr  = 1'b0;
        cyc       = 0;
        #13;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_wr_en", 64'(wr_en), 64'd0);
        checkOutput("reset_wr_data", 64'(wr_data), 64'd0);
        checkOutput("reset_grant_valid", 64'(grant_valid), 64'd0);
        checkOutput("reset_grant_id", 64'(grant_id), 64'd0);
        checkOutput("reset_stat_beats", 64'(stat_beats), 64'd0);
        @(posedge wr_clk);
        #1;
        rst_n_wr = 1'b1;

        for (int r = 0; r < 17; r++) begin
            @(posedge wr_clk);
            #1;
            applyStimulus(vecs[r], r);
            @(negedge wr_clk);
            checkOutput($sformatf("vec%0d_wr_en", r), 64'(wr_en), 64'(vecs[r].expWrEn));
            checkOutput($sformatf("vec%0d_req_ready", r), 64'(req_ready), 64'(vecs[r].expReady));
            checkOutput($sformatf("vec%0d_grant_valid", r), 64'(grant_valid), 64'(vecs[r].expGv));
            checkOutput($sformatf("vec%0d_grant_id", r), 64'(grant_id), 64'(vecs[r].expGid));
            checkOutput($sformatf("vec%0d_wr_data", r), 64'(wr_data),
                        vecs[r].expWrEn ? 64'(mkData(int'(vecs[r].expGid), 100 + r)) : 64'd0);
        end

        // Single requester, three beats ending in last.
        doReset();
        loadBeats(0, 3, 1'b0, 1'b1, 1'b1);
        driveSources();
        stepCycle();
        checkOutput("t1_grant_valid", 64'(grant_valid), 64'd1);
        checkOutput("t1_grant_id", 64'(grant_id), 64'd0);
        repeat (5) stepCycle();
        checkOutput("t1_idle_after", 64'(grant_valid), 64'd0);
        expCyc = '{1, 2, 3};
        checkCycles("t1");

        // Twenty beats with no last: capped at MAX_BURST, one idle cycle between grants.
        doReset();
        loadBeats(1, 20, 1'b0, 1'b0, 1'b1);
        driveSources();
        repeat (26) stepCycle();
        begin
            int c = 1;
            for (int b = 0; b < 20; b++) begin
                if (b > 0 && b % MAX_BURST == 0) c++;
                expCyc.push_back(c);
                c++;
            end
        end
        checkCycles("t2");

        // Round-robin with single-beat packets from everyone.
        doReset();
        for (int i = 0; i < N_REQ; i++) loadBeats(i, 3, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N_REQ; i++) sbQ.push_back('{i, mkData(i, k), 1'b1});
        driveSources();
        repeat (26) stepCycle();
        for (int k = 0; k < 12; k++) expCyc.push_back(2 * k + 1);
        checkCycles("t3");
`ifndef FIFO_ARB_STATS_EN
        stat_clr = 1'b1;
        #2;
        checkOutput("nostats_tied_zero", 64'(stat_beats), 64'd0);
        stat_clr = 1'b0;
`endif

        // Backpressure for five cycles in the middle of a burst.
        doReset();
        loadBeats(0, 6, 1'b0, 1'b1, 1'b1);
        driveSources();
        for (int c = 0; c < 15; c++) begin
            wr_full = (c >= 3 && c <= 7);
            if (wr_full) begin
                #1;
                checkOutput("t4_full_wr_en", 64'(wr_en), 64'd0);
                checkOutput("t4_full_req_ready", 64'(req_ready), 64'd0);
                checkOutput("t4_full_grant_valid", 64'(grant_valid), 64'd1);
                checkOutput("t4_full_grant_id", 64'(grant_id), 64'd0);
            end
            stepCycle();
        end
        wr_full = 1'b0;
        expCyc = '{1, 2, 8, 9, 10, 11};
        checkCycles("t4");

        // Reset asserted while the third beat of requester 2 is on the bus.
        doReset();
        loadBeats(2, 6, 1'b0, 1'b0, 1'b0);
        sbQ.push_back('{2, mkData(2, 0), 1'b0});
        sbQ.push_back('{2, mkData(2, 1), 1'b0});
        driveSources();
        repeat (3) stepCycle();
        #2;
        checkOutput("t5_beat3_wr_en", 64'(wr_en), 64'd1);
        checkOutput("t5_beat3_wr_data", 64'(wr_data), 64'(mkData(2, 2)));
        rst_n_wr = 1'b0;
        #1;
        checkOutput("t5_rst_wr_en", 64'(wr_en), 64'd0);
        checkOutput("t5_rst_grant_valid", 64'(grant_valid), 64'd0);
        checkOutput("t5_rst_req_ready", 64'(req_ready), 64'd0);
        expCyc = '{1, 2};
        checkCycles("t5a");
        srcQ.delete();
        wrCycles.delete();
        expCyc.delete();
        loadBeats(0, 1, 1'b1, 1'b0, 1'b1);
        loadBeats(2, 1, 1'b1, 1'b0, 1'b1);
        driveSources();
        @(posedge wr_clk);
        @(posedge wr_clk);
        #1;
        rst_n_wr = 1'b1;
        cyc      = 0;
        repeat (6) stepCycle();
        expCyc = '{1, 3};
        checkCycles("t5b");

`ifdef FIFO_ARB_STATS_EN
        // Forty cycles of round-robin: five beats per requester.
        doReset();
        for (int i = 0; i < N_REQ; i++) loadBeats(i, 5, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < N_REQ; i++) sbQ.push_back('{i, mkData(i, k), 1'b1});
        driveSources();
        repeat (40) stepCycle();
        for (int i = 0; i < N_REQ; i++)
            checkOutput($sformatf("t6_stat%0d", i), 64'(stat_beats[i*CNT_W +: CNT_W]), 64'd5);
        stat_clr = 1'b1;
        stepCycle();
        stat_clr = 1'b0;
        checkOutput("t6_stat_clr", 64'(stat_beats), 64'd0);

        loadBeats(0, 20, 1'b0, 1'b0, 1'b1);
        driveSources();
        repeat (26) stepCycle();
        checkOutput("t6_saturate", 64'(stat_beats[0 +: CNT_W]), 64'd15);
        checkOutput("t6_sat_others", 64'(stat_beats[N_REQ*CNT_W-1:CNT_W]), 64'd0);

        loadBeats(1, 3, 1'b0, 1'b1, 1'b1);
        driveSources();
        stepCycle();
        stat_clr = 1'b1;
        stepCycle();
        stat_clr = 1'b0;
        checkOutput("t6_clr_beats_beat", 64'(stat_beats[CNT_W +: CNT_W]), 64'd0);
        repeat (4) stepCycle();
        checkOutput("t6_after_clr", 64'(stat_beats[CNT_W +: CNT_W]), 64'd2);
        checkOutput("t6_sb_left", 64'(sbQ.size()), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
